// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the timing-block output payload.
// Also used by the drawing logic, so every boundary is derived here once.
package vga_pkg;

  // Horizontal timing in pixel clocks
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Derived sync windows (inclusive bounds)
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Widths
  localparam int unsigned HCNT_W = 10;
  localparam int unsigned VCNT_W = 10;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned FDIV_W = 8;

  // Registered output bundle of the timing block
  typedef struct packed {
    logic [X_W-1:0] screen_x;
    logic [Y_W-1:0] screen_y;
    logic           active;
    logic           hsync;
    logic           vsync;
    logic           refresh;
    logic           move_tick;
  } vga_out_t;

  // Idle value: blanked, syncs deasserted (high), no strobes
  localparam vga_out_t VGA_OUT_RST = '{
    screen_x:  '0,
    screen_y:  '0,
    active:    1'b0,
    hsync:     1'b1,
    vsync:     1'b1,
    refresh:   1'b0,
    move_tick: 1'b0
  };

endpackage

// File: rtl/vga_timing_if.sv
// Pixel-position / sync bundle produced by vga_timing.
//   screenX/screenY : current visible pixel (0 outside the visible region)
//   active          : visible pixel
//   hsync/vsync     : active-low syncs
//   refresh         : one-cycle pulse at start of vertical blanking
//   move_tick       : one-cycle game-step strobe, every MOVE_DIV-th refresh
// master = timing generator, slave = consumer (drawing logic / DAC).
interface vga_timing_if;
  import vga_pkg::*;

  logic [X_W-1:0] screenX;
  logic [Y_W-1:0] screenY;
  logic           active;
  logic           hsync;
  logic           vsync;
  logic           refresh;
  logic           move_tick;

  modport master (
    output screenX, screenY, active, hsync, vsync, refresh, move_tick
  );

  modport slave (
    input screenX, screenY, active, hsync, vsync, refresh, move_tick
  );

endinterface

// File: rtl/vga_timing.sv
// VGA 640x480 timing generator with a frame divider for the game-step strobe.
// Ports:
//   vga_clock : pixel clock, all logic on its rising edge
//   reset_n   : asynchronous active-low reset (release synchronised externally)
//   vga       : vga_timing_if master; every signal registered, one cycle behind
//               the internal (hcnt, vcnt) position
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned MOVE_DIV = 8
) (
  input  logic         vga_clock,
  input  logic         reset_n,
  vga_timing_if.master vga
);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [FDIV_W-1:0] fdiv_q, fdiv_d;
  vga_out_t          out_q, out_d;

  logic h_wrap_c;
  logic v_wrap_c;
  logic active_c;
  logic refresh_c;
  logic div_hit_c;

  // Raster position: hcnt free-runs, vcnt steps once per hcnt wrap
  always_comb begin : counter_next
    h_wrap_c = (hcnt_q == HCNT_W'(H_TOTAL - 1));
    v_wrap_c = (vcnt_q == VCNT_W'(V_TOTAL - 1));
    hcnt_d   = h_wrap_c ? '0 : hcnt_q + HCNT_W'(1);
    vcnt_d   = vcnt_q;
    if (h_wrap_c) begin
      vcnt_d = v_wrap_c ? '0 : vcnt_q + VCNT_W'(1);
    end
  end

  // Frame divider: advances on each refresh condition, strobes on the last count
  always_comb begin : divider_next
    refresh_c = (hcnt_q == '0) && (vcnt_q == VCNT_W'(V_ACTIVE));
    div_hit_c = (fdiv_q == FDIV_W'(MOVE_DIV - 1));
    fdiv_d    = fdiv_q;
    if (refresh_c) begin
      fdiv_d = div_hit_c ? '0 : fdiv_q + FDIV_W'(1);
    end
  end

  // Output decode of the current position, registered below
  always_comb begin : output_next
    active_c        = (hcnt_q < HCNT_W'(H_ACTIVE)) && (vcnt_q < VCNT_W'(V_ACTIVE));
    out_d           = VGA_OUT_RST;
    out_d.active    = active_c;
    out_d.hsync     = !((hcnt_q >= HCNT_W'(H_SYNC_START)) &&
                        (hcnt_q <= HCNT_W'(H_SYNC_END)));
    out_d.vsync     = !((vcnt_q >= VCNT_W'(V_SYNC_START)) &&
                        (vcnt_q <= VCNT_W'(V_SYNC_END)));
    out_d.refresh   = refresh_c;
    out_d.move_tick = refresh_c && div_hit_c;
    if (active_c) begin
      out_d.screen_x = X_W'(hcnt_q);
      out_d.screen_y = Y_W'(vcnt_q);
    end
  end

  // State and output registers
  always_ff @(posedge vga_clock or negedge reset_n) begin : regs
    if (!reset_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      fdiv_q <= '0;
      out_q  <= VGA_OUT_RST;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      fdiv_q <= fdiv_d;
      out_q  <= out_d;
    end
  end

  assign vga.screenX   = out_q.screen_x;
  assign vga.screenY   = out_q.screen_y;
  assign vga.active    = out_q.active;
  assign vga.hsync     = out_q.hsync;
  assign vga.vsync     = out_q.vsync;
  assign vga.refresh   = out_q.refresh;
  assign vga.move_tick = out_q.move_tick;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a MOVE_DIV=2 instance and a MOVE_DIV=1
// instance run side by side against an independent raster model.
module tb_vga_timing;

  logic vga_clock = 1'b0;
  logic reset_n;

  vga_timing_if bus2 ();
  vga_timing_if bus1 ();

  vga_timing #(.MOVE_DIV(2)) dut (
    .vga_clock (vga_clock),
    .reset_n   (reset_n),
    .vga       (bus2)
  );

  vga_timing #(.MOVE_DIV(1)) dut1 (
    .vga_clock (vga_clock),
    .reset_n   (reset_n),
    .vga       (bus1)
  );

  always #20 vga_clock = ~vga_clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model position (before the next edge), divider and cycle index
  int ph, pv, mdiv, cyc;

  // Per-cycle mismatch tallies against the model
  int err_x, err_y, err_act, err_hs, err_vs, err_ref, err_mt, err_d1;

  // Statistics
  int hs_low_cnt, hs_first_low, act_cnt, act_first, act_last;
  int c1_act, c1_x, c1_y;
  int ref_cnt, ref_cyc0, ref_cyc1, mt_cnt, mt_cyc, d1_mt_cnt;
  int vs_low_f0, vs_low_f1, max_x, max_y, blank_nonzero;
  int w0_act, w0_hs, w1_x, w1_y, w1_act;

  task automatic restart_model();
    ph = 0; pv = 0; mdiv = 0; cyc = 0;
    hs_low_cnt = 0; hs_first_low = -1; act_cnt = 0; act_first = -1; act_last = -1;
    ref_cnt = 0; ref_cyc0 = -1; ref_cyc1 = -1; mt_cnt = 0; mt_cyc = -1; d1_mt_cnt = 0;
    vs_low_f0 = 0; vs_low_f1 = 0; max_x = 0; max_y = 0; blank_nonzero = 0;
  endtask

  // One clock: sample outputs #1 after the edge, compare, then advance the model
  task automatic step();
    bit e_act, e_hs, e_vs, e_ref, e_mt;
    int e_x, e_y;
    @(posedge vga_clock);
    #1;
    cyc++;
    e_act = (ph < 640) && (pv < 480);
    e_x   = e_act ? ph : 0;
    e_y   = e_act ? pv : 0;
    e_hs  = !(ph >= 656 && ph <= 751);
    e_vs  = !(pv >= 490 && pv <= 491);
    e_ref = (ph == 0) && (pv == 480);
    e_mt  = e_ref && (mdiv == 1);
    if (e_ref) mdiv = (mdiv == 1) ? 0 : mdiv + 1;

    if (int'(bus2.screenX) != e_x) err_x++;
    if (int'(bus2.screenY) != e_y) err_y++;
    if (bus2.active    !== e_act) err_act++;
    if (bus2.hsync     !== e_hs)  err_hs++;
    if (bus2.vsync     !== e_vs)  err_vs++;
    if (bus2.refresh   !== e_ref) err_ref++;
    if (bus2.move_tick !== e_mt)  err_mt++;
    if (bus1.refresh !== e_ref || bus1.move_tick !== bus1.refresh ||
        bus1.active !== e_act || bus1.hsync !== e_hs || bus1.vsync !== e_vs) err_d1++;

    if (cyc <= 800) begin
      if (!bus2.hsync) begin
        hs_low_cnt++;
        if (hs_first_low < 0) hs_first_low = cyc;
      end
      if (bus2.active) begin
        act_cnt++;
        if (act_first < 0) act_first = cyc;
        act_last = cyc;
      end
    end
    if (cyc == 1) begin
      c1_act = int'(bus2.active); c1_x = int'(bus2.screenX); c1_y = int'(bus2.screenY);
    end
    if (cyc == 420000) begin
      w0_act = int'(bus2.active); w0_hs = int'(bus2.hsync);
    end
    if (cyc == 420001) begin
      w1_act = int'(bus2.active); w1_x = int'(bus2.screenX); w1_y = int'(bus2.screenY);
    end
    if (bus2.refresh) begin
      if (ref_cnt == 0) ref_cyc0 = cyc;
      else if (ref_cnt == 1) ref_cyc1 = cyc;
      ref_cnt++;
    end
    if (bus2.move_tick) begin
      mt_cnt++;
      mt_cyc = cyc;
    end
    if (bus1.move_tick) d1_mt_cnt++;
    if (!bus2.vsync) begin
      if (cyc <= 420000) vs_low_f0++;
      else if (cyc <= 840000) vs_low_f1++;
    end
    if (int'(bus2.screenX) > max_x) max_x = int'(bus2.screenX);
    if (int'(bus2.screenY) > max_y) max_y = int'(bus2.screenY);
    if (!bus2.active && (bus2.screenX != 0 || bus2.screenY != 0)) blank_nonzero++;

    ph++;
    if (ph == 800) begin
      ph = 0;
      pv++;
      if (pv == 525) pv = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"},    32'(bus2.screenX), 0);
    check({tag, "_y"},    32'(bus2.screenY), 0);
    check({tag, "_act"},  32'(bus2.active), 0);
    check({tag, "_hs"},   32'(bus2.hsync), 1);
    check({tag, "_vs"},   32'(bus2.vsync), 1);
    check({tag, "_ref"},  32'(bus2.refresh), 0);
    check({tag, "_mt"},   32'(bus2.move_tick), 0);
    check({tag, "_div1"}, 32'({bus1.screenX, bus1.screenY, bus1.active, bus1.hsync,
                               bus1.vsync, bus1.refresh, bus1.move_tick}), 32'h0000_000c);
  endtask

  initial begin
    err_x = 0; err_y = 0; err_act = 0; err_hs = 0;
    err_vs = 0; err_ref = 0; err_mt = 0; err_d1 = 0;
    c1_act = -1; c1_x = -1; c1_y = -1;
    w0_act = -1; w0_hs = -1; w1_act = -1; w1_x = -1; w1_y = -1;
    restart_model();

    reset_n = 1'b0;
    #50;
    check_reset("por");

    // First line after release
    @(negedge vga_clock);
    reset_n = 1'b1;
    repeat (800) step();
    check("c1_active", 32'(c1_act), 1);
    check("c1_x", 32'(c1_x), 0);
    check("c1_y", 32'(c1_y), 0);
    check("hsync_low_len", 32'(hs_low_cnt), 96);
    check("hsync_first_low", 32'(hs_first_low), 657);
    check("active_len", 32'(act_cnt), 640);
    check("active_first", 32'(act_first), 1);
    check("active_last", 32'(act_last), 640);

    // Run to position (300, 200), then reset mid-frame
    while (cyc < 200 * 800 + 300) step();
    check("pre_rst_x", 32'(bus2.screenX), 299);
    check("pre_rst_y", 32'(bus2.screenY), 200);
    #3 reset_n = 1'b0;
    #2;
    check_reset("mid_async");
    repeat (3) @(posedge vga_clock);
    #1;
    check_reset("mid_hold");

    // Fresh start: two full frames plus a margin
    @(negedge vga_clock);
    reset_n = 1'b1;
    restart_model();
    while (cyc < 850000) step();

    check("refresh_count", 32'(ref_cnt), 2);
    check("refresh_first", 32'(ref_cyc0), 384001);
    check("refresh_spacing", 32'(ref_cyc1 - ref_cyc0), 420000);
    check("move_tick_count", 32'(mt_cnt), 1);
    check("move_tick_cycle", 32'(mt_cyc), 804001);
    check("div1_move_ticks", 32'(d1_mt_cnt), 2);
    check("vsync_low_f0", 32'(vs_low_f0), 1600);
    check("vsync_low_f1", 32'(vs_low_f1), 1600);
    check("max_x", 32'(max_x), 639);
    check("max_y", 32'(max_y), 479);
    check("blank_nonzero", 32'(blank_nonzero), 0);
    check("corner_active", 32'(w0_act), 0);
    check("corner_hsync", 32'(w0_hs), 1);
    check("wrap_active", 32'(w1_act), 1);
    check("wrap_x", 32'(w1_x), 0);
    check("wrap_y", 32'(w1_y), 0);

    check("model_x", 32'(err_x), 0);
    check("model_y", 32'(err_y), 0);
    check("model_active", 32'(err_act), 0);
    check("model_hsync", 32'(err_hs), 0);
    check("model_vsync", 32'(err_vs), 0);
    check("model_refresh", 32'(err_ref), 0);
    check("model_move_tick", 32'(err_mt), 0);
    check("model_div1", 32'(err_d1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter MOVE_DIV, default 8: number of frames per move_tick pulse; legal range 1..255.
REQ-002 vga_clock  input  1  pixel clock, 25 MHz nominal; all logic on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 screenX  output  10  current pixel column, 0..639 in the visible region, 0 outside it.
REQ-005 screenY  output  9  current pixel row, 0..479 in the visible region, 0 outside it.
REQ-006 active  output  1  high while (screenX, screenY) is a visible pixel.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 refresh  output  1  one-cycle pulse marking the start of vertical blanking.
REQ-010 move_tick  output  1  one-cycle pulse on every MOVE_DIV-th refresh; this is the game-step strobe.

Function
REQ-011 Internal counter hcnt (10 bit) shall count 0..799 and wrap from 799 to 0.
REQ-012 Internal counter vcnt (10 bit) shall advance only when hcnt wraps, count 0..524, and wrap from 524 to 0.
REQ-013 Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-014 Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-015 Every output shall be registered, with one cycle of latency: the outputs after edge k are a function of (hcnt, vcnt) before edge k.
REQ-016 active shall be 1 iff hcnt<640 and vcnt<480.
REQ-017 When active=1, screenX shall equal hcnt and screenY shall equal vcnt[8:0]; otherwise both shall be 0.
REQ-018 hsync shall be 0 iff 656<=hcnt<=751.
REQ-019 vsync shall be 0 iff 490<=vcnt<=491.
REQ-020 refresh shall be 1 iff hcnt==0 and vcnt==480, giving exactly one pulse per 420000-cycle frame.
REQ-021 Frame divider fdiv (8 bit) shall update on each refresh condition:
- if fdiv==MOVE_DIV-1: fdiv goes to 0 and move_tick=1 in the same output cycle as refresh;
- otherwise fdiv increments and move_tick=0.
REQ-022 With MOVE_DIV=1, move_tick shall be identical to refresh.
REQ-023 move_tick shall never be high when refresh is low.
REQ-024 hcnt and vcnt shall wrap simultaneously at (799, 524) to (0, 0) with no skipped or duplicated line.

Reset
REQ-025 While reset_n=0, the following shall hold, independent of vga_clock:
- hcnt, vcnt and fdiv at 0;
- screenX=0, screenY=0;
- active=0, refresh=0, move_tick=0;
- hsync=1, vsync=1.
REQ-026 First edge after reset_n rises: outputs shall reflect (0,0), i.e. active=1 and screenX=0, screenY=0; hcnt becomes 1.
REQ-027 Reset asserted mid-frame shall abandon the frame immediately; the next frame after release starts at (0,0) with fdiv=0.
REQ-028 Reset release shall be synchronised by the system; the block requires no internal synchroniser.

Structure
REQ-029 Timing constants shall live in shared package vga_pkg, where the snake drawing logic also uses them:
- H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800;
- V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525.
REQ-030 All sync and blank boundaries shall be derived from the package constants; no literal boundaries in the RTL.
REQ-031 The block shall be a single module with no sub-modules; the frame divider is inline logic.

Verification
REQ-032 Release reset, run 800 cycles -> hsync low for exactly 96 consecutive cycles, first low output at cycle 657 after release; active high for cycles 1..640.
REQ-033 Run 2 full frames -> refresh pulses exactly twice, 420000 cycles apart; vsync low for exactly 1600 cycles per frame.
REQ-034 Scan the whole frame -> screenX never exceeds 639, screenY never exceeds 479, and both are 0 whenever active=0.
REQ-035 MOVE_DIV=8, run 17 frames -> move_tick on refresh numbers 8 and 16 only; MOVE_DIV=1 -> move_tick equals refresh on every frame.
REQ-036 Assert reset_n=0 at hcnt=300, vcnt=200 for 3 cycles, then release -> outputs go to reset values asynchronously; the next frame restarts at (0,0); the first move_tick arrives after MOVE_DIV refreshes.
REQ-037 Check the (799, 524) boundary -> the next output cycle shows screenX=0, screenY=0, active=1, with no extra line.
